// File: rtl/adder_operand_sequencer_if.sv
// Operand/result bundle between the adder sequencer and its surroundings.
// Signal prefixes (i_/o_) are relative to the sequencer, which uses the slave modport.
interface adder_operand_sequencer_if #(
   parameter int WIDTH = 9,
   parameter int ERR_W = 16
);
   logic             i_op_valid;
   logic             o_op_ready;
   logic [WIDTH-1:0] i_op_a;
   logic [WIDTH-1:0] i_op_b;
   logic [WIDTH-1:0] o_add1;
   logic [WIDTH-1:0] o_add2;
   logic [WIDTH:0]   i_result;
   logic             o_res_valid;
   logic             i_res_ready;
   logic [WIDTH:0]   o_res_data;
   logic             o_res_mismatch;
   logic             i_err_clear;
   logic [ERR_W-1:0] o_err_count;
   logic             o_busy;

   modport slave (
      input  i_op_valid, i_op_a, i_op_b, i_result, i_res_ready, i_err_clear,
      output o_op_ready, o_add1, o_add2, o_res_valid, o_res_data,
             o_res_mismatch, o_err_count, o_busy
   );

   modport master (
      output i_op_valid, i_op_a, i_op_b, i_result, i_res_ready, i_err_clear,
      input  o_op_ready, o_add1, o_add2, o_res_valid, o_res_data,
             o_res_mismatch, o_err_count, o_busy
   );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Launches registered operands into the CLA adder, samples its result after
// SETTLE_CYCLES edges, flags disagreement with a behavioural sum, counts errors.
module adder_operand_sequencer #(
   parameter int WIDTH         = 9,
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 16
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   adder_operand_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

   // SETTLE_CYCLES is limited to 1..15, so a 4-bit down-counter suffices.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] add1_q, add1_d;
   logic [WIDTH-1:0] add2_q, add2_d;
   logic [WIDTH:0]   exp_q, exp_d;
   logic [WIDTH:0]   res_data_q, res_data_d;
   logic             res_vld_q, res_vld_d;
   logic             mismatch_q, mismatch_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             sample;
   logic             sample_bad;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      add1_d     = add1_q;
      add2_d     = add2_q;
      exp_d      = exp_q;
      res_data_d = res_data_q;
      res_vld_d  = res_vld_q;
      mismatch_d = mismatch_q;
      sample     = 1'b0;
      sample_bad = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.i_op_valid) begin
               add1_d  = bus.i_op_a;
               add2_d  = bus.i_op_b;
               exp_d   = {1'b0, bus.i_op_a} + {1'b0, bus.i_op_b};
               cnt_d   = CNT_INIT;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               sample     = 1'b1;
               sample_bad = (bus.i_result != exp_q);
               res_data_d = bus.i_result;
               mismatch_d = sample_bad;
               res_vld_d  = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // Result data is left in place after the handshake; only the qualifiers drop.
            if (bus.i_res_ready) begin
               res_vld_d  = 1'b0;
               mismatch_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (bus.i_err_clear) begin
         err_d = '0;
      end else if (sample && sample_bad && (err_q != '1)) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         add1_q     <= '0;
         add2_q     <= '0;
         exp_q      <= '0;
         res_data_q <= '0;
         res_vld_q  <= 1'b0;
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         add1_q     <= add1_d;
         add2_q     <= add2_d;
         exp_q      <= exp_d;
         res_data_q <= res_data_d;
         res_vld_q  <= res_vld_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
      end
   end

   // Ready derives from registered state only, so a result handshake never
   // reaches the operand side in the same cycle.
   assign bus.o_op_ready     = (state_q == IDLE);
   assign bus.o_busy         = (state_q != IDLE);
   assign bus.o_add1         = add1_q;
   assign bus.o_add2         = add2_q;
   assign bus.o_res_valid    = res_vld_q;
   assign bus.o_res_data     = res_data_q;
   assign bus.o_res_mismatch = mismatch_q;
   assign bus.o_err_count    = err_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer: three instances cover SETTLE=1,
// SETTLE=3 and a 2-bit error counter; expected results flow through a scoreboard queue.
module tb_adder_operand_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: SETTLE=1/ERR_W=16, 1: SETTLE=3/ERR_W=16, 2: SETTLE=1/ERR_W=2
   logic [2:0]       rst_n;
   logic [2:0]       op_valid;
   logic [2:0][8:0]  op_a;
   logic [2:0][8:0]  op_b;
   logic [2:0]       res_ready;
   logic [2:0]       err_clear;
   logic [2:0]       force_bad;

   logic [2:0]       op_ready;
   logic [2:0][8:0]  add1;
   logic [2:0][8:0]  add2;
   logic [2:0]       res_valid;
   logic [2:0][9:0]  res_data;
   logic [2:0]       mism;
   logic [2:0][15:0] err_cnt;
   logic [2:0]       busy;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int SC = (g == 1) ? 3 : 1;
      localparam int EW = (g == 2) ? 2 : 16;

      adder_operand_sequencer_if #(.WIDTH(9), .ERR_W(EW)) bus ();

      assign bus.i_op_valid  = op_valid[g];
      assign bus.i_op_a      = op_a[g];
      assign bus.i_op_b      = op_b[g];
      assign bus.i_res_ready = res_ready[g];
      assign bus.i_err_clear = err_clear[g];
      // Behavioural stand-in for the CLA adder, optionally forced to a wrong value.
      assign bus.i_result    = force_bad[g] ? 10'd0 : ({1'b0, bus.o_add1} + {1'b0, bus.o_add2});

      assign op_ready[g]  = bus.o_op_ready;
      assign add1[g]      = bus.o_add1;
      assign add2[g]      = bus.o_add2;
      assign res_valid[g] = bus.o_res_valid;
      assign res_data[g]  = bus.o_res_data;
      assign mism[g]      = bus.o_res_mismatch;
      assign err_cnt[g]   = 16'(bus.o_err_count);
      assign busy[g]      = bus.o_busy;

      adder_operand_sequencer #(
         .WIDTH(9), .SETTLE_CYCLES(SC), .ERR_W(EW)
      ) u_dut (
         .i_clk  (clk),
         .i_rst_n(rst_n[g]),
         .bus    (bus.slave)
      );
   end

   typedef struct {
      logic [9:0]  data;
      logic        mism;
      logic [15:0] err;
   } exp_t;

   exp_t sb[$];
   int   err_model[3];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // One full transaction on instance g; stall = cycles of i_res_ready=0 after the sample.
   task automatic run_txn(input int g, input logic [8:0] a, input logic [8:0] b,
                          input bit bad, input int stall, input bit clr);
      int   sc;
      int   maxv;
      exp_t e;
      exp_t got;
      sc   = (g == 1) ? 3 : 1;
      maxv = (g == 2) ? 3 : 65535;

      @(negedge clk);
      chk("idle_ready", op_ready[g], 1'b1);
      op_a[g]      = a;
      op_b[g]      = b;
      op_valid[g]  = 1'b1;
      force_bad[g] = bad;
      res_ready[g] = 1'b0;

      if (clr) err_model[g] = 0;
      else if (bad && err_model[g] < maxv) err_model[g]++;
      e.data = bad ? 10'd0 : ({1'b0, a} + {1'b0, b});
      e.mism = bad;
      e.err  = 16'(err_model[g]);
      sb.push_back(e);

      @(negedge clk);
      op_valid[g] = 1'b0;
      op_a[g]     = ~a;
      op_b[g]     = ~b;
      chk("ready_low_after_accept", op_ready[g], 1'b0);
      chk("busy_after_accept", busy[g], 1'b1);
      chk("add1_launch", add1[g], a);
      chk("add2_launch", add2[g], b);
      chk("no_early_valid", res_valid[g], 1'b0);
      for (int k = 1; k < sc; k++) begin
         @(negedge clk);
         chk("no_early_valid_settle", res_valid[g], 1'b0);
      end
      err_clear[g] = clr;
      res_ready[g] = (stall == 0);

      @(negedge clk);
      err_clear[g] = 1'b0;
      chk("valid_at_sample", res_valid[g], 1'b1);
      got = sb.pop_front();
      if (res_valid[g]) begin
         chk("res_data", res_data[g], got.data);
         chk("res_mismatch", mism[g], got.mism);
         chk("err_count", err_cnt[g], got.err);
      end

      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("hold_valid", res_valid[g], 1'b1);
         chk("hold_data", res_data[g], got.data);
         chk("hold_ready_low", op_ready[g], 1'b0);
         chk("hold_add1", add1[g], a);
         chk("hold_add2", add2[g], b);
      end
      res_ready[g] = 1'b1;

      @(negedge clk);
      chk("valid_drop", res_valid[g], 1'b0);
      chk("mismatch_drop", mism[g], 1'b0);
      chk("ready_back", op_ready[g], 1'b1);
      chk("busy_clear", busy[g], 1'b0);
      chk("data_retained", res_data[g], got.data);
      chk("add1_retained", add1[g], a);
   endtask

   initial begin
      rst_n     = '0;
      op_valid  = '0;
      op_a      = '0;
      op_b      = '0;
      res_ready = '1;
      err_clear = '0;
      force_bad = '0;
      for (int g = 0; g < 3; g++) err_model[g] = 0;

      repeat (2) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk("rst_valid", res_valid[g], 1'b0);
         chk("rst_busy", busy[g], 1'b0);
         chk("rst_add1", add1[g], 9'd0);
         chk("rst_data", res_data[g], 10'd0);
         chk("rst_err", err_cnt[g], 16'd0);
      end
      rst_n = '1;

      run_txn(0, 9'd255, 9'd1, 1'b0, 0, 1'b0);
      run_txn(1, 9'd511, 9'd511, 1'b0, 0, 1'b0);
      run_txn(0, 9'd3, 9'd4, 1'b0, 5, 1'b0);
      run_txn(0, 9'd3, 9'd4, 1'b1, 0, 1'b0);
      run_txn(0, 9'd3, 9'd4, 1'b1, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         run_txn(2, 9'(i + 10), 9'(i * 3), 1'b1, 0, 1'b0);
      end

      // Reset while instance 1 is settling: transaction dropped, outputs cleared at once.
      @(negedge clk);
      op_a[1]     = 9'd100;
      op_b[1]     = 9'd200;
      op_valid[1] = 1'b1;
      @(negedge clk);
      op_valid[1] = 1'b0;
      chk("mid_busy", busy[1], 1'b1);
      rst_n[1] = 1'b0;
      #1;
      chk("mid_rst_add1", add1[1], 9'd0);
      chk("mid_rst_add2", add2[1], 9'd0);
      chk("mid_rst_busy", busy[1], 1'b0);
      chk("mid_rst_valid", res_valid[1], 1'b0);
      chk("mid_rst_data", res_data[1], 10'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mid_rst_no_valid", res_valid[1], 1'b0);
      end
      rst_n[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_no_valid", res_valid[1], 1'b0);
      end
      run_txn(1, 9'd1, 9'd1, 1'b0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
- Sequencing stage that sits directly upstream and downstream of the combinational 9-bit carry-lookahead adder.
- Accepts operand pairs over a valid/ready handshake and drives them, registered, onto the adder inputs.
- Waits a programmable settle time, then captures the adder result and checks it against a behavioural sum.
- Presents the result plus a mismatch flag downstream over a valid/ready handshake and keeps a saturating error count.

Parameters:
- WIDTH, 9: operand width; the result is WIDTH+1 bits.
- SETTLE_CYCLES, 1: clock edges between operand launch and result sample; legal range 1..15.
- ERR_W, 16: width of the error counter.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_op_valid  input  1  operand pair valid.
- o_op_ready  output  1  sequencer can accept an operand pair.
- i_op_a  input  WIDTH  operand A.
- i_op_b  input  WIDTH  operand B.
- o_add1  output  WIDTH  registered operand to adder i_add1.
- o_add2  output  WIDTH  registered operand to adder i_add2.
- i_result  input  WIDTH+1  adder o_result, with the carry-out as the MSB.
- o_res_valid  output  1  captured result available.
- i_res_ready  input  1  downstream accepts the result.
- o_res_data  output  WIDTH+1  captured adder result.
- o_res_mismatch  output  1  captured result differs from the expected sum.
- i_err_clear  input  1  synchronous clear of the error counter.
- o_err_count  output  ERR_W  saturating mismatch count.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_add1, o_add2, o_res_data, o_err_count all zero.
  - o_res_valid=0, o_res_mismatch=0, o_busy=0.
  - Internal expected-sum register and settle counter are zero.
  - Takes effect immediately, in any state; an in-flight transaction is dropped with no output.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - o_op_ready=1.
  - On edge E0 with i_op_valid=1:
    - o_add1<=i_op_a, o_add2<=i_op_b.
    - exp<=i_op_a+i_op_b, zero-extended to WIDTH+1 bits.
    - cnt<=SETTLE_CYCLES-1.
    - Go to SETTLE.
- SETTLE:
  - o_op_ready=0; i_op_valid is ignored.
  - Each edge: if cnt!=0 then cnt<=cnt-1; else sample.
  - Sample action:
    - o_res_data<=i_result.
    - o_res_mismatch<=(i_result!=exp).
    - o_res_valid<=1.
    - Go to HOLD.
  - The result is therefore sampled on edge E0+SETTLE_CYCLES, and o_res_valid is high after that edge.
- HOLD:
  - o_op_ready=0.
  - o_res_valid, o_res_data and o_res_mismatch are held stable until the edge where i_res_ready=1.
  - On that edge: o_res_valid<=0, o_res_mismatch<=0, go to IDLE. o_res_data keeps its last value.
  - There is no combinational path from i_res_ready to o_op_ready. The next operand is accepted no earlier than the edge after the result handshake.
  - Throughput is at most one transaction per SETTLE_CYCLES+2 cycles.
- o_add1/o_add2:
  - Change only on IDLE acceptance.
  - Held stable through SETTLE and HOLD, and after return to IDLE until the next acceptance.
- Error counter (evaluated on the sample edge):
  - If mismatch and o_err_count<2^ERR_W-1, increment by 1.
  - At 2^ERR_W-1 it holds; no wrap.
  - i_err_clear=1 sets it to 0 on that edge.
  - If a clear and an increment coincide, clear wins and the counter is 0.
- Arithmetic:
  - exp is unsigned with a full carry. The maximum is (2^WIDTH-1)*2 = 1022 for WIDTH=9.
  - Comparison is over all WIDTH+1 bits.
- i_op_a/i_op_b changing while not in IDLE has no effect.
- o_busy = (state!=IDLE), registered-state derived.

Test Plan:
- Reset, then a=255, b=1, i_result driven by the real adder, i_res_ready=1.
  - o_op_ready=0 from E0+1.
  - o_res_valid=1 after E0+1, with o_res_data=0x100 and o_res_mismatch=0.
  - o_err_count=0 and back in IDLE after E0+2.
- a=511, b=511 with SETTLE_CYCLES=3.
  - Sample occurs on E0+3; o_res_data=0x3FE (1022), carry bit set, mismatch=0.
  - o_res_valid is not high before E0+3.
- Backpressure: a=3, b=4, i_res_ready held 0 for 5 cycles.
  - o_res_valid stays 1 with o_res_data=7 stable; o_op_ready stays 0; o_add1=3 and o_add2=4 stable.
  - After i_res_ready=1, o_res_valid drops the next edge and o_op_ready=1.
- Fault injection: a=3, b=4 with i_result forced to 0.
  - o_res_mismatch=1 and o_err_count=1.
  - Repeat with i_err_clear=1 on the sample edge: o_err_count=0 (clear wins).
- Saturation: ERR_W=2, force 5 consecutive mismatches.
  - o_err_count reads 1, 2, 3, 3, 3.
- Reset mid-SETTLE (SETTLE_CYCLES=3, i_rst_n low at E0+1).
  - All outputs zero immediately and o_res_valid never asserts.
  - After release, a=1, b=1 completes normally with o_res_data=2.
